// File: rtl/fetch_unit_pq.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_pq
// Brief    : Instruction fetch with prefetch queue, valid/ready memory port and
//            redirect flush that drops stale in-flight responses.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit_pq #(
   parameter int              XLEN      = 32,
   parameter int              DEPTH     = 4,
   parameter int              MAX_OUTST = 2,
   parameter logic [XLEN-1:0] RESET_PC  = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr_data,
   output logic [XLEN-1:0] instr_pc,
   output logic [XLEN-1:0] instr_pc_plus4
);
   localparam int c_PW = $clog2(DEPTH);
   localparam int c_CW = $clog2(MAX_OUTST + 1);
   localparam logic [c_PW:0] c_PTR_ONE = 1;

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   logic [c_PW:0]   r_alloc, r_fill, r_head;
   logic [XLEN-1:0] r_fetchPc;
   logic [c_CW-1:0] r_discard;
   logic [XLEN-1:0] r_pcMem   [DEPTH];
   logic [XLEN-1:0] r_dataMem [DEPTH];

   logic [c_PW:0]   w_inflight, w_occupancy;
   logic [31:0]     w_outst;
   logic            w_reqFire, w_rspTake, w_rspWrite, w_pop, w_headValid;
   logic [XLEN-1:0] w_redirTarget;
   logic [c_CW-1:0] w_redirDiscard;

   assign w_inflight  = r_alloc - r_fill;
   assign w_occupancy = r_alloc - r_head;
   assign w_outst     = 32'(w_inflight) + 32'(r_discard);
   assign w_headValid = (r_fill != r_head);

   assign imem_req_valid = !reset && !redirect_valid
                           && (32'(w_occupancy) < 32'(DEPTH))
                           && (w_outst < 32'(MAX_OUTST));
   assign imem_req_addr  = r_fetchPc;
   assign w_reqFire      = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding is a protocol error and is ignored
   assign w_rspTake  = imem_rsp_valid && (w_outst != 32'd0);
   assign w_rspWrite = w_rspTake && (r_discard == '0);
   assign w_pop      = w_headValid && instr_ready && !redirect_valid;

   assign w_redirTarget  = redirect_pc & ~XLEN'(3);
   // Everything still in flight becomes stale; a same-cycle response retires one
   assign w_redirDiscard = r_discard + c_CW'(w_inflight) - c_CW'(w_rspTake);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_alloc   <= '0;
         r_fill    <= '0;
         r_head    <= '0;
         r_fetchPc <= RESET_PC;
         r_discard <= '0;
      end else if (redirect_valid) begin
         r_alloc   <= '0;
         r_fill    <= '0;
         r_head    <= '0;
         r_fetchPc <= w_redirTarget;
         r_discard <= w_redirDiscard;
      end else begin
         if (w_reqFire) begin
            r_alloc   <= r_alloc + c_PTR_ONE;
            r_fetchPc <= r_fetchPc + XLEN'(4);
         end
         if (w_rspTake) begin
            if (r_discard != '0)
               r_discard <= r_discard - 1'b1;
            else
               r_fill <= r_fill + c_PTR_ONE;
         end
         if (w_pop)
            r_head <= r_head + c_PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (w_reqFire)
         r_pcMem[r_alloc[c_PW-1:0]] <= r_fetchPc;
      if (w_rspWrite && !redirect_valid)
         r_dataMem[r_fill[c_PW-1:0]] <= imem_rsp_data;
   end

   assign instr_valid    = w_headValid;
   assign instr_data     = w_headValid ? r_dataMem[r_head[c_PW-1:0]] : '0;
   assign instr_pc       = w_headValid ? r_pcMem[r_head[c_PW-1:0]] : '0;
   assign instr_pc_plus4 = w_headValid ? (r_pcMem[r_head[c_PW-1:0]] + XLEN'(4)) : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit_pq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit_pq
// Brief    : Self-checking bench: queue-level model plus memory responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit_pq;
   localparam int          XLEN      = 32;
   localparam int          DEPTH     = 4;
   localparam int          MAX_OUTST = 2;
   localparam logic [31:0] RESET_PC  = 32'hFFFF_FFF8;

   logic        clk = 1'b0;
   logic        reset;
   logic        imemReqValid, imemReqReady;
   logic [31:0] imemReqAddr;
   logic        imemRspValid;
   logic [31:0] imemRspData;
   logic        redirectValid;
   logic [31:0] redirectPc;
   logic        instrValid, instrReady;
   logic [31:0] instrData, instrPc, instrPcPlus4;

   fetch_unit_pq #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset(reset),
      .imem_req_valid(imemReqValid), .imem_req_ready(imemReqReady), .imem_req_addr(imemReqAddr),
      .imem_rsp_valid(imemRspValid), .imem_rsp_data(imemRspData),
      .redirect_valid(redirectValid), .redirect_pc(redirectPc),
      .instr_valid(instrValid), .instr_ready(instrReady), .instr_data(instrData),
      .instr_pc(instrPc), .instr_pc_plus4(instrPcPlus4)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] memData(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
   endfunction

   // Model: a program-order list of fetched slots plus a count of stale responses
   typedef struct { logic [31:0] pc; logic [31:0] data; bit filled; } slot_t;
   slot_t       mQ[$];
   logic [31:0] mPc;
   int          mStale;

   function automatic int mUnfilled();
      int n = 0;
      foreach (mQ[i]) if (!mQ[i].filled) n++;
      return n;
   endfunction

   function automatic int mFilled();
      return mQ.size() - mUnfilled();
   endfunction

   function automatic bit pReqValid();
      return !reset && !redirectValid && (mQ.size() < DEPTH) && ((mUnfilled() + mStale) < MAX_OUTST);
   endfunction

   function automatic bit pInstrValid();
      return !reset && (mQ.size() > 0) && mQ[0].filled;
   endfunction

   function automatic logic [31:0] expPc();
      if (!pInstrValid()) return 32'h0;
      return mQ[0].pc;
   endfunction

   function automatic logic [31:0] expData();
      if (!pInstrValid()) return 32'h0;
      return mQ[0].data;
   endfunction

   task automatic modelReset();
      mQ.delete();
      mPc    = RESET_PC;
      mStale = 0;
   endtask

   task automatic modelStep();
      bit    fire, pop, rsp;
      int    outst;
      slot_t s;
      fire  = pReqValid() && imemReqReady;
      pop   = pInstrValid() && instrReady;
      outst = mUnfilled() + mStale;
      rsp   = imemRspValid && (outst > 0);
      if (redirectValid) begin
         mStale = outst - (rsp ? 1 : 0);
         mQ.delete();
         mPc = redirectPc & 32'hFFFF_FFFC;
      end else begin
         if (rsp) begin
            if (mStale > 0) mStale--;
            else begin
               for (int i = 0; i < mQ.size(); i++) begin
                  if (!mQ[i].filled) begin
                     s = mQ[i]; s.filled = 1'b1; s.data = imemRspData; mQ[i] = s;
                     break;
                  end
               end
            end
         end
         if (pop) void'(mQ.pop_front());
         if (fire) begin
            s.pc = mPc; s.data = 32'h0; s.filled = 1'b0;
            mQ.push_back(s);
            mPc = mPc + 32'd4;
         end
      end
   endtask

   // Memory responder: in-order, fixed latency, fed by what the DUT actually issued
   typedef struct { logic [31:0] addr; int due; } req_t;
   req_t        memQ[$];
   logic [31:0] accepted[$];
   int          memLat = 1;
   int          cyc = 0;
   logic        capReqValid;
   logic [31:0] capReqAddr;

   function automatic logic [31:0] accAt(input int idx);
      if (idx >= accepted.size()) return 32'hDEAD_BEEF;
      return accepted[idx];
   endfunction

   always @(negedge clk) begin
      capReqValid = imemReqValid;
      capReqAddr  = imemReqAddr;
      check("cmp_req_valid", 32'(imemReqValid), 32'(pReqValid()));
      if (pReqValid()) check("cmp_req_addr", imemReqAddr, mPc);
      check("cmp_instr_valid", 32'(instrValid), 32'(pInstrValid()));
      check("cmp_instr_data", instrData, expData());
      check("cmp_instr_pc", instrPc, expPc());
      check("cmp_instr_pc_plus4", instrPcPlus4, pInstrValid() ? expPc() + 32'd4 : 32'h0);
   end

   task automatic tick();
      req_t r;
      @(posedge clk);
      if (reset) memQ.delete();
      else begin
         modelStep();
         if (capReqValid && imemReqReady) begin
            r.addr = capReqAddr; r.due = cyc + memLat;
            memQ.push_back(r);
            accepted.push_back(capReqAddr);
         end
      end
      cyc++;
      #1;
      redirectValid = 1'b0;
      if (!reset && memQ.size() > 0 && memQ[0].due <= cyc) begin
         imemRspValid = 1'b1;
         imemRspData  = memData(memQ[0].addr);
         void'(memQ.pop_front());
      end else begin
         imemRspValid = 1'b0;
         imemRspData  = 32'h0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      reset = 1'b1; imemReqReady = 1'b1; imemRspValid = 1'b0; imemRspData = 32'h0;
      redirectValid = 1'b0; redirectPc = 32'h0; instrReady = 1'b1;
      modelReset();
      #1;
      check("rst_req_valid", 32'(imemReqValid), 32'd0);
      check("rst_instr_valid", 32'(instrValid), 32'd0);
      check("rst_instr_pc", instrPc, 32'h0);
      tick(); tick();
      reset = 1'b0;
      #1;
      check("first_req_valid", 32'(imemReqValid), 32'd1);
      check("first_req_addr", imemReqAddr, 32'hFFFF_FFF8);

      // Streaming from a reset PC near the top of the address space
      tick(); #1; check("wrap_addr1", imemReqAddr, 32'hFFFF_FFFC);
      tick(); #1; check("wrap_valid0", 32'(instrValid), 32'd1); check("wrap_pc0", instrPc, 32'hFFFF_FFF8);
      tick(); #1; check("wrap_pc1", instrPc, 32'hFFFF_FFFC); check("wrap_plus4_1", instrPcPlus4, 32'h0);
      tick(); #1; check("wrap_pc2", instrPc, 32'h0); check("wrap_data2", instrData, memData(32'h0));
      repeat (4) tick();

      // Memory stalls
      for (int i = 0; i < 6; i++) begin
         imemReqReady = 1'(i % 2);
         tick();
      end
      imemReqReady = 1'b1;
      repeat (3) tick();

      // Decode stalled: queue fills with exactly DEPTH entries then drains in order
      instrReady = 1'b0; redirectValid = 1'b1; redirectPc = 32'h0;
      accepted.delete();
      repeat (12) tick();
      #1;
      check("full_req_valid", 32'(imemReqValid), 32'd0);
      check("full_count", 32'(accepted.size()), 32'd4);
      check("full_first", accAt(0), 32'h0);
      check("full_last", accAt(3), 32'hC);
      check("full_head_pc", instrPc, 32'h0);
      instrReady = 1'b1;
      repeat (6) tick();
      check("resume_addr", accAt(4), 32'h10);

      // Long latency, two in flight, redirect to a misaligned target
      memLat = 3;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         tick();
         if (mUnfilled() == 2 && mStale == 0) found = 1'b1;
      end
      check("lat3_two_inflight", 32'(found), 32'd1);
      redirectValid = 1'b1; redirectPc = 32'h103;
      accepted.delete();
      tick(); #1;
      check("redir_addr", imemReqAddr, 32'h100);
      check("redir_empty", 32'(instrValid), 32'd0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (pInstrValid()) found = 1'b1;
      end
      #1;
      check("redir_delivered", 32'(found), 32'd1);
      check("redir_first_pc", instrPc, 32'h100);
      check("redir_first_data", instrData, memData(32'h100));
      check("redir_first_issue", accAt(0), 32'h100);

      // Redirect colliding with a response and a decode handshake
      memLat = 1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (imemRspValid && pInstrValid() && mUnfilled() == 1 && mStale == 0) found = 1'b1;
      end
      check("collide_setup", 32'(found), 32'd1);
      redirectValid = 1'b1; redirectPc = 32'h200;
      tick(); #1;
      check("collide_empty", 32'(instrValid), 32'd0);
      check("collide_req_valid", 32'(imemReqValid), 32'd1);
      check("collide_req_addr", imemReqAddr, 32'h200);
      repeat (4) tick();

      // Asynchronous reset with entries queued and a response still owed
      memLat = 2; instrReady = 1'b0;
      redirectValid = 1'b1; redirectPc = 32'h400;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (mFilled() >= 2 && mUnfilled() >= 1) found = 1'b1;
      end
      check("midrst_setup", 32'(found), 32'd1);
      #2;
      reset = 1'b1; modelReset(); imemRspValid = 1'b0;
      #1;
      check("midrst_instr_valid", 32'(instrValid), 32'd0);
      check("midrst_instr_pc", instrPc, 32'h0);
      check("midrst_instr_data", instrData, 32'h0);
      check("midrst_plus4", instrPcPlus4, 32'h0);
      check("midrst_req_valid", 32'(imemReqValid), 32'd0);
      tick(); tick();
      reset = 1'b0; instrReady = 1'b1; memLat = 1;
      #1;
      check("postrst_addr", imemReqAddr, RESET_PC);
      check("postrst_valid", 32'(imemReqValid), 32'd1);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         if (pInstrValid()) found = 1'b1;
      end
      #1;
      check("postrst_delivered", 32'(found), 32'd1);
      check("postrst_pc", instrPc, RESET_PC);
      check("postrst_data", instrData, memData(RESET_PC));
      repeat (5) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/fetch_unit_pq.md
Name: fetch_unit_pq

Overview:
- Parametrised successor to the single-cycle fetch path (PC register, PC+4 adder, next-PC mux, instruction memory).
- Decouples PC generation from decode with an instruction prefetch queue.
- Talks to instruction memory through a valid/ready request and an in-order response with latency of 1 cycle or more.
- Accepts redirects (branch/jump) that flush the queue and discard stale in-flight responses; feeds decode through a valid/ready handshake.

Parameters:
- XLEN, 32, address/instruction width.
- DEPTH, 4, prefetch queue entries; power of 2, at least 2.
- MAX_OUTST, 2, maximum outstanding memory requests (stale ones included); at least 1.
- RESET_PC, 0, fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid; in order; no back-pressure.
- imem_rsp_data  in  XLEN  instruction word.
- redirect_valid  in  1  redirect request.
- redirect_pc  in  XLEN  redirect target; bits [1:0] ignored (treated as 0).
- instr_valid  out  1  queue head holds a returned instruction.
- instr_ready  in  1  decode consumes the head.
- instr_data  out  XLEN  head instruction.
- instr_pc  out  XLEN  head PC.
- instr_pc_plus4  out  XLEN  head PC + 4, mod 2^XLEN.

Behaviour:
- Reset (asynchronous, any cycle, including mid-transfer):
  - fetch_pc = RESET_PC; head, fill and alloc pointers = 0; discard_cnt = 0.
  - imem_req_valid = 0 and instr_valid = 0 while reset is high.
  - instr_data, instr_pc and instr_pc_plus4 read 0 while instr_valid = 0.
- Queue model: three wrap-around pointers, each with an extra wrap bit.
  - alloc: advances when a request is accepted; the slot's PC is written at allocation.
  - fill: advances when a non-discarded response is written into the slot's data.
  - head: advances on an instr_valid && instr_ready handshake.
  - inflight = alloc - fill. occupancy = alloc - head, never above DEPTH.
- Request issue:
  - imem_req_valid = !reset && !redirect_valid && occupancy < DEPTH && (inflight + discard_cnt) < MAX_OUTST.
  - imem_req_addr = fetch_pc.
  - On acceptance (valid && ready), fetch_pc += 4 (wraps mod 2^XLEN) and alloc advances.
  - A request may be withdrawn before acceptance only by a redirect; otherwise valid and addr stay stable until ready.
- Response:
  - If discard_cnt > 0, the response is dropped and discard_cnt decrements.
  - Otherwise data is written at fill and fill advances.
  - A response that arrives with inflight + discard_cnt == 0 is a protocol error: ignore it and raise no output.
- Output: instr_valid = (fill != head). The fields come from the head slot.
- Latency:
  - Response in cycle t gives instr_valid in cycle t+1 if the queue was empty.
  - After reset deasserts, the first request is presented in the first cycle.
- Redirect (redirect_valid = 1, cycle t):
  - Has priority over every other event in the same cycle.
  - Cycle t: no request issued, and any handshake with decode is void.
  - At edge t: head = fill = alloc = 0 and fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - discard_cnt = discard_cnt + inflight - (imem_rsp_valid ? 1 : 0). The cycle-t response is consumed as stale.
  - Cycle t+1: instr_valid = 0 and a request to the new PC may issue.
  - Back-to-back redirects: the last one wins, and the discard count accumulates correctly.
- Simultaneous pop and response on a full queue: allowed. A slot freed by a pop becomes allocatable the next cycle (no same-cycle bypass).
- Queue full (occupancy == DEPTH): no request; held responses are kept.
- Queue empty: instr_valid = 0.
- Throughput: one instruction per cycle sustained when memory is 1-cycle latency, always ready, and MAX_OUTST is at least 2.

Test Plan:
- Reset release, memory with 1-cycle latency, ready = 1, instr_ready = 1 -> addresses 0,4,8,... issued every cycle; instr_pc 0,4,8 in consecutive cycles from cycle 2; instr_pc_plus4 = instr_pc + 4.
- instr_ready = 0 and DEPTH = 4 -> exactly 4 requests issued (0x0–0xC), then imem_req_valid = 0; releasing ready drains in order, and fetch resumes at 0x10.
- Memory with 3-cycle latency, MAX_OUTST = 2, two requests in flight, redirect_pc = 0x103 -> next request address 0x100; both stale responses dropped; first instr_pc = 0x100.
- Redirect in the same cycle as a response and a decode handshake -> response dropped, handshake void, discard_cnt = inflight - 1; queue empty in the next cycle.
- RESET_PC = 0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0; instr_pc_plus4 of the second = 0x0.
- Reset asserted mid-stream with 2 queued and 1 in flight -> outputs go to 0 asynchronously; after release, fetch restarts at RESET_PC with no stale data delivered (bench must not return the old response).
